lynx_video_fetch: RTL and testbench



---
 rtl/lynx_video_fetch.sv | 128 ++++++++++++
 tb/tb_lynx_video_fetch.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lynx_video_fetch.sv
// Lynx video fetch/shift stage: line/pixel counters, bitplane RAM addressing and serial RGB with sync/blank/irq.
// Optional macro VIDEO_BORDER_EN adds a border colour input shown during blanking outside sync.
module lynx_video_fetch #(
    parameter int unsigned H_TOTAL  = 448,
    parameter int unsigned V_ACTIVE = 248,
    parameter int unsigned V_TOTAL  = 312,
    parameter int unsigned HS_START = 320,
    parameter int unsigned HS_WIDTH = 32,
    parameter int unsigned VS_START = 270,
    parameter int unsigned VS_WIDTH = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
`ifdef VIDEO_BORDER_EN
    input  logic [2:0]  border,
`endif
    output logic [12:0] a1,
    input  logic [7:0]  qr,
    input  logic [7:0]  qg,
    input  logic [7:0]  qb,
    output logic        r,
    output logic        g,
    output logic        b,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        irq
);
    localparam int unsigned HC_W     = $clog2(H_TOTAL);
    localparam int unsigned VC_W     = (V_TOTAL > 2) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned H_ACTIVE = 256;

    logic [HC_W-1:0] hc;
    logic [HC_W-1:0] hc_nxt;
    logic [VC_W-1:0] vc;
    logic [VC_W-1:0] vc_nxt;
    logic [VC_W-1:0] vc_inc;
    logic [VC_W-1:0] row_vc;
    logic [HC_W:0]   hc_fetch;
    logic [7:0]      row;
    logic [4:0]      col;
    logic [7:0]      sr_r;
    logic [7:0]      sr_g;
    logic [7:0]      sr_b;
    logic            hs_c;
    logic            vs_c;
    logic            blank_c;
    logic [2:0]      pix_c;

    // Counter advance, fetch address (three pixels ahead, wrapping into the next line) and pixel decode
    always_comb begin
        vc_inc   = (vc == VC_W'(V_TOTAL - 1)) ? '0 : vc + 1'b1;
        hc_nxt   = hc + 1'b1;
        vc_nxt   = vc;
        if (hc == HC_W'(H_TOTAL - 1)) begin
            hc_nxt = '0;
            vc_nxt = vc_inc;
        end

        hc_fetch = {1'b0, hc} + (HC_W + 1)'(3);
        row_vc   = vc;
        if (32'(hc_fetch) >= H_TOTAL) begin
            hc_fetch = hc_fetch - (HC_W + 1)'(H_TOTAL);
            row_vc   = vc_inc;
        end
        col = 5'(hc_fetch >> 3);
        row = 8'(row_vc);

        hs_c    = (32'(hc) >= HS_START) && (32'(hc) < HS_START + HS_WIDTH);
        vs_c    = (32'(vc) >= VS_START) && (32'(vc) < VS_START + VS_WIDTH);
        blank_c = (32'(hc) >= H_ACTIVE) || (32'(vc) >= V_ACTIVE);

        pix_c = {sr_r[7], sr_g[7], sr_b[7]};
        if (blank_c) begin
`ifdef VIDEO_BORDER_EN
            pix_c = (hs_c || vs_c) ? 3'b000 : border;
`else
            pix_c = 3'b000;
`endif
        end
    end

    // All timing state advances on ce; irq is a single-clock pulse regardless of ce
    always_ff @(posedge clock) begin
        if (reset) begin
            hc    <= '0;
            vc    <= '0;
            a1    <= '0;
            sr_r  <= '0;
            sr_g  <= '0;
            sr_b  <= '0;
            r     <= 1'b0;
            g     <= 1'b0;
            b     <= 1'b0;
            hsync <= 1'b0;
            vsync <= 1'b0;
            blank <= 1'b1;
            irq   <= 1'b0;
        end else begin
            irq <= 1'b0;
            if (ce) begin
                hc <= hc_nxt;
                vc <= vc_nxt;
                if (hc[2:0] == 3'd5) begin
                    a1 <= {row, col};
                end
                // RAM data addressed two ce earlier is stable by the hc[2:0]==7 edge
                if (hc[2:0] == 3'd7) begin
                    sr_r <= qr;
                    sr_g <= qg;
                    sr_b <= qb;
                end else begin
                    sr_r <= {sr_r[6:0], 1'b0};
                    sr_g <= {sr_g[6:0], 1'b0};
                    sr_b <= {sr_b[6:0], 1'b0};
                end
                r     <= pix_c[2];
                g     <= pix_c[1];
                b     <= pix_c[0];
                hsync <= hs_c;
                vsync <= vs_c;
                blank <= blank_c;
                irq   <= vs_c & ~vsync;
            end
        end
    end
endmodule

// File: tb/tb_lynx_video_fetch.sv
// Scoreboard bench for lynx_video_fetch: driver pushes expected outputs per edge, monitor pops and compares.
// Uses a short frame (16 lines) to keep full-frame runs brief.
`timescale 1ns/1ps
module tb_lynx_video_fetch;
    localparam int unsigned H_TOTAL  = 448;
    localparam int unsigned V_ACTIVE = 8;
    localparam int unsigned V_TOTAL  = 16;
    localparam int unsigned HS_START = 320;
    localparam int unsigned HS_WIDTH = 32;
    localparam int unsigned VS_START = 10;
    localparam int unsigned VS_WIDTH = 3;
    localparam int unsigned FRAME_CE = H_TOTAL * V_TOTAL;

    typedef struct packed {
        logic        r;
        logic        g;
        logic        b;
        logic        hsync;
        logic        vsync;
        logic        blank;
        logic        irq;
        logic [12:0] a1;
    } out_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ce    = 1'b0;
    logic [12:0] a1;
    logic [7:0]  qr, qg, qb;
    logic        r, g, b, hsync, vsync, blank, irq;
`ifdef VIDEO_BORDER_EN
    logic [2:0]  border_val = 3'b110;
`else
    logic [2:0]  border_val = 3'b000;
`endif

    int   errors = 0;
    int   checks = 0;
    bit   const_mode = 1'b1;
    bit   started = 1'b0;
    int   m_hc = 0, m_vc = 0;
    bit   m_first = 1'b1;
    out_t m_last = '0;
    out_t exp_q[$];

    lynx_video_fetch #(
        .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
        .HS_START(HS_START), .HS_WIDTH(HS_WIDTH), .VS_START(VS_START), .VS_WIDTH(VS_WIDTH)
    ) dut (
        .clock(clock), .reset(reset), .ce(ce),
`ifdef VIDEO_BORDER_EN
        .border(border_val),
`endif
        .a1(a1), .qr(qr), .qg(qg), .qb(qb),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync), .blank(blank), .irq(irq)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] ram_byte(input int unsigned plane, input logic [12:0] a);
        if (const_mode) begin
            case (plane)
                0: return 8'hA5;
                1: return 8'h00;
                default: return 8'hFF;
            endcase
        end
        case (plane)
            0: return a[7:0] ^ 8'h5A;
            1: return {a[4:0], a[12:10]};
            default: return ~a[12:5];
        endcase
    endfunction

    // One-clock-latency plane RAMs
    always @(posedge clock) begin
        qr <= ram_byte(0, a1);
        qg <= ram_byte(1, a1);
        qb <= ram_byte(2, a1);
    end

    function automatic logic [2:0] exp_pix(input int h, input int v, input bit blk, input bit sync, input bit first);
        logic [12:0] a;
        logic [7:0]  br, bg, bb;
        int          k;
        if (blk) return sync ? 3'b000 : border_val;
        if (first && h < 8) return 3'b000;
        a  = {8'(v), 5'(h / 8)};
        k  = 7 - (h % 8);
        br = ram_byte(0, a);
        bg = ram_byte(1, a);
        bb = ram_byte(2, a);
        return {br[k], bg[k], bb[k]};
    endfunction

    task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push_model(input bit c, input bit rs);
        out_t e;
        bit   hs, vs, blk;
        int   ah, av;
        if (rs) begin
            e       = '0;
            e.blank = 1'b1;
            m_hc    = 0;
            m_vc    = 0;
            m_first = 1'b1;
            started = 1'b1;
            exp_q.push_back(e);
            m_last  = e;
        end else if (c) begin
            hs  = (m_hc >= HS_START) && (m_hc < HS_START + HS_WIDTH);
            vs  = (m_vc >= VS_START) && (m_vc < VS_START + VS_WIDTH);
            blk = (m_hc >= 256) || (m_vc >= V_ACTIVE);
            e       = m_last;
            e.hsync = hs;
            e.vsync = vs;
            e.blank = blk;
            e.irq   = vs && !m_last.vsync;
            {e.r, e.g, e.b} = exp_pix(m_hc, m_vc, blk, hs || vs, m_first);
            if (m_hc % 8 == 5) begin
                ah = m_hc + 3;
                av = m_vc;
                if (ah >= H_TOTAL) begin
                    ah = ah - H_TOTAL;
                    av = (m_vc + 1) % V_TOTAL;
                end
                e.a1 = {8'(av), 5'(ah / 8)};
            end
            if (m_hc % 8 == 7) m_first = 1'b0;
            if (m_hc == H_TOTAL - 1) begin
                m_hc = 0;
                m_vc = (m_vc + 1) % V_TOTAL;
            end else begin
                m_hc = m_hc + 1;
            end
            exp_q.push_back(e);
            m_last = e;
        end
    endtask

    task automatic tick(input bit c, input bit rs);
        @(negedge clock);
        ce    = c;
        reset = rs;
        push_model(c, rs);
        @(posedge clock);
        #1;
    endtask

    // Monitor: every reset/ce edge consumes one expected record; other edges must hold with irq low
    always begin : monitor
        logic s_ce, s_rst;
        out_t e, hold;
        @(posedge clock);
        s_ce  = ce;
        s_rst = reset;
        #1;
        if (started) begin
            if (s_rst || s_ce) begin
                if (exp_q.size() == 0) begin
                    chk("queue_empty", 20'd1, 20'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_on_ce", {r, g, b, hsync, vsync, blank, irq, a1}, e);
                end
            end else begin
                hold     = m_last;
                hold.irq = 1'b0;
                chk("out_hold", {r, g, b, hsync, vsync, blank, irq, a1}, hold);
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        int         ce_idx, last_irq, irq_cnt, hs_cnt;
        pat = 8'hA5;

        // Reset with ce, line 0 and 1 with constant plane data
        const_mode = 1'b1;
        tick(0, 1);
        tick(1, 1);
        chk("reset_outs", {r, g, b, hsync, vsync, blank, irq, a1}, {7'b0000010, 13'd0});
        for (int v = 0; v < 2; v++) begin
            for (int h = 0; h < int'(H_TOTAL); h++) begin
                tick(1, 0);
                if (v == 0 && h == 5)   chk("a1_hc5", 20'(a1), 20'h0001);
                if (v == 0 && h == 445) chk("a1_hc445", 20'(a1), 20'h0020);
                if (v == 0 && h < 8)    chk("black_after_reset", 20'({r, g, b}), 20'd0);
                if ((v == 0 && h >= 8 && h < 16) || (v == 1 && h < 8))
                    chk("pix_const", 20'({r, g, b}), 20'({pat[7 - (h % 8)], 1'b0, 1'b1}));
                if (h == 255) chk("blank_vis", 20'(blank), 20'd0);
                if (h == 256) chk("blank_h256", 20'(blank), 20'd1);
            end
        end

        // ce every third clock: same pixel stream
        tick(1, 1);
        for (int h = 0; h < int'(H_TOTAL); h++) begin
            tick(1, 0);
            if (h == 5) chk("a1_hc5_slow", 20'(a1), 20'h0001);
            if (h >= 8 && h < 16)
                chk("pix_slow", 20'({r, g, b}), 20'({pat[7 - (h % 8)], 1'b0, 1'b1}));
            tick(0, 0);
            tick(0, 0);
        end

        // Pattern plane data, two full frames with sync/irq checks
        const_mode = 1'b0;
        tick(1, 1);
        ce_idx = 0; last_irq = -1; irq_cnt = 0; hs_cnt = 0;
        for (int f = 0; f < 2; f++) begin
            for (int v = 0; v < int'(V_TOTAL); v++) begin
                for (int h = 0; h < int'(H_TOTAL); h++) begin
                    tick(1, 0);
                    ce_idx++;
                    if (f == 0 && v == 0) begin
                        if (hsync) hs_cnt++;
                        if (h == 319) chk("hsync_319", 20'(hsync), 20'd0);
                        if (h == 320) chk("hsync_320", 20'(hsync), 20'd1);
                        if (h == 351) chk("hsync_351", 20'(hsync), 20'd1);
                        if (h == 352) chk("hsync_352", 20'(hsync), 20'd0);
                        if (h == 300) chk("border_300", 20'({r, g, b}), 20'(border_val));
                        if (h == 330) chk("sync_black", 20'({r, g, b}), 20'd0);
                    end
                    if (f == 0 && h == 0)
                        chk("vsync_line", 20'(vsync), 20'(v >= 10 && v < 13));
                    if (irq) begin
                        irq_cnt++;
                        chk("irq_pos", 20'({4'(v), 9'(h)}), 20'({4'd10, 9'd0}));
                        if (last_irq >= 0) chk("frame_period", 20'(ce_idx - last_irq), 20'(FRAME_CE));
                        last_irq = ce_idx;
                    end
                end
            end
        end
        chk("hsync_width", 20'(hs_cnt), 20'd32);
        chk("irq_count", 20'(irq_cnt), 20'd2);

        // Irregular ce spacing
        for (int i = 0; i < 3 * int'(H_TOTAL); i++) begin
            tick(1, 0);
            repeat ($urandom_range(0, 2)) tick(0, 0);
        end

        // Reset mid-frame without ce
        for (int i = 0; i < 2 * int'(FRAME_CE) && !(m_hc == 100 && m_vc == 5); i++) tick(1, 0);
        chk("reach_mid", 20'({4'(m_vc), 9'(m_hc)}), 20'({4'd5, 9'd100}));
        tick(0, 1);
        chk("midreset_outs", {r, g, b, hsync, vsync, blank, irq, a1}, {7'b0000010, 13'd0});
        for (int h = 0; h < int'(H_TOTAL); h++) begin
            tick(1, 0);
            if (h == 5)   chk("a1_hc5_rst", 20'(a1), 20'h0001);
            if (h == 445) chk("a1_hc445_rst", 20'(a1), 20'h0020);
            if (h < 8)    chk("black_after_midreset", 20'({r, g, b}), 20'd0);
        end
        tick(0, 0);
        tick(0, 0);
        chk("queue_drained", 20'(exp_q.size()), 20'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
